load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage front end that sits directly upstream of the data memory.
- Takes EX/MEM access requests (byte address, store data, Funct3) and turns them into word-aligned memory accesses with per-byte write enables and lane-shifted store data.
- Extracts and extends load results back into the pipeline.
- Misaligned halfword/word accesses become two back-to-back aligned accesses, controlled by a small FSM that stalls the pipeline.

Parameters:
- DM_ADDRESS, 9, byte-address width of data memory (word index = a[DM_ADDRESS-1:2])
- DATA_W, 32, data width (fixed 32; other values unsupported)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- MemRead  input  1  load request from EX/MEM
- MemWrite  input  1  store request from EX/MEM
- Funct3  input  3  instruction bits 14:12
- a  input  DM_ADDRESS  byte address (ALU result LSBs)
- wd  input  DATA_W  unshifted store data (rs2)
- mem_addr  output  DM_ADDRESS  word-aligned address to memory (bits 1:0 = 0)
- mem_wdata  output  DATA_W  lane-shifted store data
- mem_be  output  4  byte write enables; all zero when not writing
- mem_re  output  1  memory read strobe
- mem_rdata  input  DATA_W  memory read data, valid combinationally in the same cycle as mem_addr
- rd  output  DATA_W  extended load result (registered)
- rd_valid  output  1  one-cycle pulse, rd valid
- stall  output  1  hold IF/ID/EX and EX/MEM this cycle

Behaviour:
- Reset: state=IDLE; rd=0, rd_valid=0, hold regs=0.
  - Combinational outputs under reset: stall=0, mem_be=0, mem_re=0.
  - Reset in SPLIT aborts the second half: no write, no rd_valid.
- Priority: MemRead over MemWrite when both are high.
- Sizes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other Funct3 = word.
- Lane math: off=a[1:0].
  - Store data shifted left by 8*off.
  - Byte enables = size mask (0001/0011/1111) shifted left by off.
  - Load bytes shifted right by 8*off, then zero- or sign-extended per Funct3.
- Misaligned when off+size_bytes > 4 (LH/SH at off=3; LW/SW at off!=0).
- Aligned access (IDLE, single cycle):
  - mem_addr={a[hi:2],00}; mem_be/mem_re driven combinationally.
  - For a load, rd registered at the clock edge; rd_valid=1 in the next cycle.
  - stall=0.
- Misaligned access, cycle 0 (IDLE):
  - Issue word W0 with the low part of the mask (mask<<off, bits 3:0).
  - Capture W0 read bytes, funct3, off, next-word address and upper wd into hold regs.
  - stall=1; go to SPLIT.
- Misaligned access, cycle 1 (SPLIT):
  - Issue word W1=(W0+1) mod 2^(DM_ADDRESS-2), i.e. the address wraps.
  - Upper mask = (mask<<off)>>4; data taken from hold regs only (inputs ignored).
  - Loads: combine W1 lanes with held W0 bytes, extend, register rd; rd_valid next cycle.
  - stall=0; go to IDLE.
- rd holds its last value when rd_valid=0.
- No request in IDLE: mem_be=0, mem_re=0, stall=0.
- Back-to-back aligned accesses sustain one per cycle.
- A new request in the cycle after SPLIT is accepted normally.

Decomposition:
- Shared package lsu_pkg:
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, SPLIT}.
  - Function size_mask(funct3) returning the 4-bit mask.
- One sub-module, load_extend: pure combinational; takes a 32-bit raw word, off and funct3, and returns the extended result. Used for both the aligned path and the SPLIT combine path.

Test Plan:
- Aligned LW: mem[0x10]=0xDEADBEEF; LW a=0x10 -> mem_addr=0x10, mem_re=1, stall=0; next cycle rd=0xDEADBEEF, rd_valid=1.
- Aligned LB/LBU: mem[0x10]=0x80FF7F01.
  - LB a=0x13 -> rd=0xFFFFFF80.
  - LBU a=0x13 -> rd=0x00000080.
  - LH a=0x12 -> rd=0xFFFF80FF.
- Aligned SB: SB a=0x21, wd=0x000000AB -> mem_addr=0x20, mem_be=0010, mem_wdata[15:8]=0xAB, stall=0.
- Misaligned SW: SW a=0x07, wd=0x11223344.
  - Cycle 0: mem_addr=0x04, mem_be=1000, mem_wdata[31:24]=0x44, stall=1.
  - Cycle 1: mem_addr=0x08, mem_be=0111, mem_wdata[23:0]=0x112233, stall=0.
- Misaligned LW with wrap: mem[0x1FC]=0xAABBCCDD, mem[0x000]=0x11223344; LW a=0x1FE.
  - Cycle 0: mem_addr=0x1FC, stall=1.
  - Cycle 1: mem_addr=0x000.
  - Next cycle: rd=0x3344AABB, rd_valid=1.
- Reset mid-split: LH a=0x03 then reset=1 in the SPLIT cycle -> no W1 write/read result, rd=0, rd_valid=0, stall=0, state IDLE after the edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: Funct3 size codes, FSM state
// and the byte-lane mask for each access size.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, SPLIT} lsu_state_t;

    // Unrecognised Funct3 encodings fall back to a full word.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = 4'b0001;
            F3_H, F3_HU: mask = 4'b0011;
            default:     mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extraction: shifts the addressed bytes down to lane 0 and applies
// zero or sign extension according to Funct3.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    assign shifted = raw_i >> {off_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result_o = {24'h000000, shifted[7:0]};
            F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result_o = {16'h0000, shifted[15:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: aligns stores into byte lanes, extends loads,
// and splits misaligned halfword/word accesses into two aligned word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  stall
);

    localparam int unsigned AW = DM_ADDRESS - 2;

    lsu_state_t          state_q, state_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   w0_q, w0_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [DATA_W-1:0]   wd_hi_q, wd_hi_d;
    logic                load_q, load_d;
    logic                store_q, store_d;

    logic [1:0]          off;
    logic [AW-1:0]       word_idx;
    logic [7:0]          mask_sh;
    logic [7:0]          hold_mask_sh;
    logic                misaligned;
    logic [2*DATA_W-1:0] wd_sh;
    logic [2*DATA_W-1:0] pair_sh;
    logic [DATA_W-1:0]   ext_raw;
    logic [1:0]          ext_off;
    logic [2:0]          ext_f3;
    logic [DATA_W-1:0]   ext_result;

    assign off          = a[1:0];
    assign word_idx     = a[DM_ADDRESS-1:2];
    assign mask_sh      = {4'b0000, size_mask(Funct3)} << off;
    assign hold_mask_sh = {4'b0000, size_mask(f3_q)} << off_q;
    assign misaligned   = |mask_sh[7:4];
    // Upper half of the shifted store data feeds the second word of a split store.
    assign wd_sh        = {{DATA_W{1'b0}}, wd} << {off, 3'b000};
    assign pair_sh      = {mem_rdata, w0_q} >> {off_q, 3'b000};

    // In SPLIT the two words are pre-combined, so the extender sees offset zero.
    assign ext_raw = (state_q == SPLIT) ? pair_sh[DATA_W-1:0] : mem_rdata;
    assign ext_off = (state_q == SPLIT) ? 2'b00 : off;
    assign ext_f3  = (state_q == SPLIT) ? f3_q : Funct3;

    load_extend u_load_extend (
        .raw_i    (ext_raw),
        .off_i    (ext_off),
        .funct3_i (ext_f3),
        .result_o (ext_result)
    );

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        w0_d       = w0_q;
        f3_d       = f3_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        wd_hi_d    = wd_hi_q;
        load_d     = load_q;
        store_d    = store_q;
        mem_addr   = {word_idx, 2'b00};
        mem_wdata  = wd_sh[DATA_W-1:0];
        mem_be     = 4'b0000;
        mem_re     = 1'b0;
        stall      = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        mem_re = MemRead;
                        if (!MemRead) begin
                            mem_be = mask_sh[3:0];
                        end
                        if (misaligned) begin
                            stall   = 1'b1;
                            state_d = SPLIT;
                            w0_d    = mem_rdata;
                            f3_d    = Funct3;
                            off_d   = off;
                            waddr_d = word_idx + AW'(1);
                            wd_hi_d = wd_sh[2*DATA_W-1:DATA_W];
                            load_d  = MemRead;
                            store_d = !MemRead;
                        end else if (MemRead) begin
                            rd_valid_d = 1'b1;
                            rd_d       = ext_result;
                        end
                    end
                end
                SPLIT: begin
                    mem_addr  = {waddr_q, 2'b00};
                    mem_wdata = wd_hi_q;
                    mem_re    = load_q;
                    mem_be    = store_q ? hold_mask_sh[7:4] : 4'b0000;
                    if (load_q) begin
                        rd_valid_d = 1'b1;
                        rd_d       = ext_result;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            w0_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            waddr_q    <= '0;
            wd_hi_q    <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            w0_q       <= w0_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            wd_hi_q    <= wd_hi_d;
            load_q     <= load_d;
            store_q    <= store_d;
        end
    end

    assign rd       = rd_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a load-result
// scoreboard, plus reset-abort sequences for split accesses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [31:0] rd;
    logic        rd_valid;
    logic        stall;

    logic        mem_init;
    logic [31:0] mem [0:127];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .a         (a),
        .wd        (wd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .rd        (rd),
        .rd_valid  (rd_valid),
        .stall     (stall)
    );

    // Data memory model: combinational read, byte-enabled write at the clock edge.
    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[7'h04] <= 32'hDEADBEEF;
            mem[7'h7F] <= 32'hAABBCCDD;
            mem[7'h00] <= 32'h11223344;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Scoreboard: every rd_valid pulse consumes one expected load result.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_sb_unexpected: got rd_valid with rd=%08h want no result", rd);
            end else begin
                last_rd = exp_q.pop_front();
                chk("rd_sb", rd, last_rd);
            end
        end
    end

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        logic        split;
        logic [8:0]  addr0;
        logic [3:0]  be0;
        logic [31:0] wdat0;
        logic [8:0]  addr1;
        logic [3:0]  be1;
        logic [31:0] wdat1;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f,
                                input logic [8:0] ad, input logic [31:0] d, input logic sp,
                                input logic [8:0] a0, input logic [3:0] b0,
                                input logic [31:0] w0, input logic [8:0] a1,
                                input logic [3:0] b1, input logic [31:0] w1,
                                input logic [31:0] er);
        vec_t v;
        v.rd_en = r;   v.wr_en = w;   v.f3 = f;     v.a = ad;     v.wd = d;
        v.split = sp;  v.addr0 = a0;  v.be0 = b0;   v.wdat0 = w0;
        v.addr1 = a1;  v.be1 = b1;    v.wdat1 = w1; v.exp_rd = er;
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [8:0] ad, input logic [31:0] d);
        MemRead = r; MemWrite = w; Funct3 = f; a = ad; wd = d;
    endtask

    task automatic check_cycle(input string tag, input logic [8:0] ea, input logic [3:0] ebe,
                               input logic [31:0] ewd, input logic ere, input logic est);
        chk({tag, "_addr"}, {23'h0, mem_addr}, {23'h0, ea});
        chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, ebe});
        chk({tag, "_re"}, {31'h0, mem_re}, {31'h0, ere});
        chk({tag, "_stall"}, {31'h0, stall}, {31'h0, est});
        if (ebe != 4'b0000) chk({tag, "_wdata"}, mem_wdata & lane_mask(ebe), ewd);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.rd_en, v.wr_en, v.f3, v.a, v.wd);
        if (v.rd_en) exp_q.push_back(v.exp_rd);
        @(negedge clk);
        check_cycle($sformatf("v%0d_c0", idx), v.addr0, v.be0, v.wdat0, v.rd_en, v.split);
        @(posedge clk); #1;
        if (v.split) begin
            // Inputs must be ignored during the second half.
            drive(1'b0, 1'b1, 3'b000, 9'h155, 32'h5A5A5A5A);
            @(negedge clk);
            check_cycle($sformatf("v%0d_c1", idx), v.addr1, v.be1, v.wdat1, v.rd_en, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    vec_t vt [$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        r  w  f3  a       wd            sp a0     be0   wdat0         a1     be1   wdat1         exp_rd
        vt.push_back(mk(1, 0, 3'd2, 9'h010, 32'h0,        0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'hDEADBEEF));
        vt.push_back(mk(0, 1, 3'd2, 9'h010, 32'h80FF7F01, 0, 9'h010, 4'hF, 32'h80FF7F01, 9'h0,   4'h0, 32'h0,        32'h0));
        vt.push_back(mk(1, 0, 3'd0, 9'h013, 32'h0,        0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'hFFFFFF80));
        vt.push_back(mk(1, 0, 3'd4, 9'h013, 32'h0,        0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'h00000080));
        vt.push_back(mk(1, 0, 3'd1, 9'h012, 32'h0,        0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'hFFFF80FF));
        vt.push_back(mk(1, 0, 3'd5, 9'h011, 32'h0,        0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'h0000FF7F));
        vt.push_back(mk(1, 1, 3'd2, 9'h010, 32'hFFFFFFFF, 0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'h80FF7F01));
        vt.push_back(mk(1, 0, 3'd3, 9'h010, 32'h0,        0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'h80FF7F01));
        vt.push_back(mk(0, 0, 3'd2, 9'h010, 32'h0,        0, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'h0));
        vt.push_back(mk(0, 1, 3'd0, 9'h021, 32'h000000AB, 0, 9'h020, 4'h2, 32'h0000AB00, 9'h0,   4'h0, 32'h0,        32'h0));
        vt.push_back(mk(0, 1, 3'd2, 9'h007, 32'h11223344, 1, 9'h004, 4'h8, 32'h44000000, 9'h008, 4'h7, 32'h00112233, 32'h0));
        vt.push_back(mk(1, 0, 3'd2, 9'h006, 32'h0,        1, 9'h004, 4'h0, 32'h0,        9'h008, 4'h0, 32'h0,        32'h22334400));
        vt.push_back(mk(0, 1, 3'd1, 9'h023, 32'h1234BEEF, 1, 9'h020, 4'h8, 32'hEF000000, 9'h024, 4'h1, 32'h000000BE, 32'h0));
        vt.push_back(mk(1, 0, 3'd5, 9'h023, 32'h0,        1, 9'h020, 4'h0, 32'h0,        9'h024, 4'h0, 32'h0,        32'h0000BEEF));
        vt.push_back(mk(1, 0, 3'd1, 9'h023, 32'h0,        1, 9'h020, 4'h0, 32'h0,        9'h024, 4'h0, 32'h0,        32'hFFFFBEEF));
        vt.push_back(mk(1, 0, 3'd2, 9'h1FE, 32'h0,        1, 9'h1FC, 4'h0, 32'h0,        9'h000, 4'h0, 32'h0,        32'h3344AABB));
        vt.push_back(mk(0, 1, 3'd1, 9'h1FF, 32'h00005566, 1, 9'h1FC, 4'h8, 32'h66000000, 9'h000, 4'h1, 32'h00000055, 32'h0));
        vt.push_back(mk(1, 0, 3'd1, 9'h1FF, 32'h0,        1, 9'h1FC, 4'h0, 32'h0,        9'h000, 4'h0, 32'h0,        32'h00005566));
        vt.push_back(mk(0, 1, 3'd1, 9'h002, 32'h0000CAFE, 0, 9'h000, 4'hC, 32'hCAFE0000, 9'h0,   4'h0, 32'h0,        32'h0));
        vt.push_back(mk(1, 0, 3'd2, 9'h000, 32'h0,        0, 9'h000, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'hCAFE3355));
        vt.push_back(mk(1, 0, 3'd0, 9'h001, 32'h0,        0, 9'h000, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0,        32'h00000033));

        // Reset with requests present: outputs must stay quiet.
        mem_init = 1'b1;
        reset    = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 9'h010, 32'h0);
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_rd", rd, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_re", {31'h0, mem_re}, 32'h0);
        drive(1'b0, 1'b1, 3'd2, 9'h007, 32'hFFFFFFFF);
        @(negedge clk);
        chk("rst_be", {28'h0, mem_be}, 32'h0);
        chk("rst_stall_mis", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vt[i]) apply_vec(vt[i], i);
        drive(1'b0, 1'b0, 3'd0, 9'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Misaligned load aborted by reset in its SPLIT cycle.
        drive(1'b1, 1'b0, 3'd1, 9'h003, 32'h0);
        @(negedge clk);
        check_cycle("abort_ld_c0", 9'h000, 4'h0, 32'h0, 1'b1, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 9'h0, 32'h0);
        @(negedge clk);
        chk("abort_ld_stall", {31'h0, stall}, 32'h0);
        chk("abort_ld_re", {31'h0, mem_re}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ld_rd", rd, 32'h0);
        chk("abort_ld_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("abort_ld_stall_after", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;

        // Misaligned store aborted by reset: first half lands, second must not.
        drive(1'b0, 1'b1, 3'd2, 9'h005, 32'hA1B2C3D4);
        @(negedge clk);
        check_cycle("abort_st_c0", 9'h004, 4'hE, 32'hB2C3D400, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_st_be", {28'h0, mem_be}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 3'd2, 9'h008, 32'h0);
        exp_q.push_back(32'h00112233);
        @(negedge clk);
        check_cycle("post_abort_ld8", 9'h008, 4'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd2, 9'h004, 32'h0);
        exp_q.push_back(32'hB2C3D400);
        @(negedge clk);
        check_cycle("post_abort_ld4", 9'h004, 4'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 9'h0, 32'h0);
        repeat (3) @(negedge clk);

        chk("sb_empty", exp_q.size(), 32'h0);
        chk("rd_hold_valid", {31'h0, rd_valid}, 32'h0);
        chk("rd_hold", rd, 32'hB2C3D400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
